// File: rtl/ex_muldiv_seq_if.sv
// Request/response bundle between the EX stage and the iterative mul/div sequencer.
interface ex_muldiv_seq_if #(
  parameter int XLEN     = 32,
  parameter int REG_BITS = 5
);
  logic                start;
  logic [2:0]          op;
  logic [XLEN-1:0]     op_a;
  logic [XLEN-1:0]     op_b;
  logic [REG_BITS-1:0] dest_reg;
  logic                flush;
  logic                busy;
  logic                stall;
  logic                done;
  logic [XLEN-1:0]     result;
  logic [REG_BITS-1:0] res_reg;

  modport master (
    output start, op, op_a, op_b, dest_reg, flush,
    input  busy, stall, done, result, res_reg
  );

  modport slave (
    input  start, op, op_a, op_b, dest_reg, flush,
    output busy, stall, done, result, res_reg
  );
endinterface

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M-style multiply/divide sequencer: one shift-add or restoring-divide step per cycle.
// Optional macro MULDIV_SIGNED_EN enables signed MULH/DIV/REM (ops 4-6); otherwise they are reserved.
module ex_muldiv_seq #(
  parameter int XLEN     = 32,
  parameter int REG_BITS = 5
) (
  input  logic           clk,
  input  logic           rst,
  ex_muldiv_seq_if.slave bus
);
  localparam int              CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_MULHU = 3'd1;
  localparam logic [2:0] OP_DIVU  = 3'd2;
  localparam logic [2:0] OP_REMU  = 3'd3;
  localparam logic [2:0] OP_MULH  = 3'd4;
  localparam logic [2:0] OP_DIV   = 3'd5;
  localparam logic [2:0] OP_REM   = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic op_is_div(input logic [2:0] op);
    case (op)
      OP_DIVU, OP_REMU, OP_DIV, OP_REM: op_is_div = 1'b1;
      default:                          op_is_div = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_rem(input logic [2:0] op);
    case (op)
      OP_REMU, OP_REM: op_is_rem = 1'b1;
      default:         op_is_rem = 1'b0;
    endcase
  endfunction

  function automatic logic op_reserved(input logic [2:0] op);
    case (op)
      OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: op_reserved = 1'b0;
`ifdef MULDIV_SIGNED_EN
      OP_MULH, OP_DIV, OP_REM:            op_reserved = 1'b0;
`endif
      default:                            op_reserved = 1'b1;
    endcase
  endfunction

`ifdef MULDIV_SIGNED_EN
  function automatic logic op_is_signed(input logic [2:0] op);
    case (op)
      OP_MULH, OP_DIV, OP_REM: op_is_signed = 1'b1;
      default:                 op_is_signed = 1'b0;
    endcase
  endfunction
`endif

  state_t              state_r, state_nxt;
  logic [CNT_W-1:0]    cnt_r;
  logic [2:0]          op_r;
  logic [XLEN-1:0]     hi_r, lo_r, b_r;
  logic [XLEN-1:0]     hi_nxt, lo_nxt;
  logic [XLEN-1:0]     result_r, run_result_s, fast_result_s;
  logic [XLEN-1:0]     a_mag_s, b_mag_s;
  logic [REG_BITS-1:0] res_reg_r;
  logic                busy_r, done_r;
  logic                accept_s, fast_s, stall_s, last_s;
  logic [XLEN:0]       sum_s, trial_s;
  logic [2*XLEN-1:0]   prod_s;
  logic [XLEN-1:0]     quo_s, rem_s;
`ifdef MULDIV_SIGNED_EN
  logic                neg_r, neg_nxt_s;
`endif

  // Request decode: accept, fast-path detection and operand conditioning.
  always_comb begin
    accept_s = bus.start & ~bus.flush & ((state_r == IDLE) | (state_r == DONE));
    fast_s   = op_reserved(bus.op) | (op_is_div(bus.op) & (bus.op_b == {XLEN{1'b0}}));
    if (op_reserved(bus.op)) begin
      fast_result_s = {XLEN{1'b0}};
    end else if (op_is_rem(bus.op)) begin
      fast_result_s = bus.op_a;
    end else begin
      fast_result_s = {XLEN{1'b1}};
    end
`ifdef MULDIV_SIGNED_EN
    a_mag_s   = (op_is_signed(bus.op) & bus.op_a[XLEN-1]) ? -bus.op_a : bus.op_a;
    b_mag_s   = (op_is_signed(bus.op) & bus.op_b[XLEN-1]) ? -bus.op_b : bus.op_b;
    neg_nxt_s = op_is_signed(bus.op) &
                (op_is_rem(bus.op) ? bus.op_a[XLEN-1] : (bus.op_a[XLEN-1] ^ bus.op_b[XLEN-1]));
`else
    a_mag_s   = bus.op_a;
    b_mag_s   = bus.op_b;
`endif
  end

  // One datapath step: hi/lo hold product halves or remainder/quotient.
  always_comb begin
    sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {(XLEN+1){1'b0}});
    trial_s = {hi_r, lo_r[XLEN-1]} - {1'b0, b_r};
    if (op_is_div(op_r)) begin
      if (!trial_s[XLEN]) begin
        hi_nxt = trial_s[XLEN-1:0];
        lo_nxt = {lo_r[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = {hi_r[XLEN-2:0], lo_r[XLEN-1]};
        lo_nxt = {lo_r[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nxt = sum_s[XLEN:1];
      lo_nxt = {sum_s[0], lo_r[XLEN-1:1]};
    end
  end

  // Result of the final iteration, sign-corrected when signed ops are built in.
  always_comb begin
`ifdef MULDIV_SIGNED_EN
    prod_s = neg_r ? -{hi_nxt, lo_nxt} : {hi_nxt, lo_nxt};
    quo_s  = neg_r ? -lo_nxt : lo_nxt;
    rem_s  = neg_r ? -hi_nxt : hi_nxt;
`else
    prod_s = {hi_nxt, lo_nxt};
    quo_s  = lo_nxt;
    rem_s  = hi_nxt;
`endif
    case (op_r)
      OP_MUL:            run_result_s = prod_s[XLEN-1:0];
      OP_MULHU, OP_MULH: run_result_s = prod_s[2*XLEN-1:XLEN];
      OP_DIVU, OP_DIV:   run_result_s = quo_s;
      OP_REMU, OP_REM:   run_result_s = rem_s;
      default:           run_result_s = {XLEN{1'b0}};
    endcase
  end

  // Next-state logic and the combinational pipeline hold.
  always_comb begin
    state_nxt = state_r;
    last_s    = (cnt_r == CNT_LAST);
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          state_nxt = fast_s ? DONE : RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_nxt = IDLE;
        end else if (last_s) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
    stall_s = (state_r == RUN) | (accept_s & ~fast_s);
  end

  // State, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      result_r  <= {XLEN{1'b0}};
      res_reg_r <= {REG_BITS{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      op_r      <= 3'd0;
      hi_r      <= {XLEN{1'b0}};
      lo_r      <= {XLEN{1'b0}};
      b_r       <= {XLEN{1'b0}};
`ifdef MULDIV_SIGNED_EN
      neg_r     <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt;
      busy_r  <= (state_nxt != IDLE);
      done_r  <= (state_nxt == DONE);
      if (accept_s) begin
        op_r      <= bus.op;
        hi_r      <= {XLEN{1'b0}};
        lo_r      <= a_mag_s;
        b_r       <= b_mag_s;
        cnt_r     <= {CNT_W{1'b0}};
        res_reg_r <= bus.dest_reg;
`ifdef MULDIV_SIGNED_EN
        neg_r     <= neg_nxt_s;
`endif
        if (fast_s) begin
          result_r <= fast_result_s;
        end
      end else if (state_r == RUN) begin
        hi_r  <= hi_nxt;
        lo_r  <= lo_nxt;
        cnt_r <= cnt_r + CNT_ONE;
        // A flush on the last iteration must leave the previous result visible.
        if (last_s && !bus.flush) begin
          result_r <= run_result_s;
        end
      end
    end
  end

  assign bus.busy    = busy_r;
  assign bus.stall   = stall_s;
  assign bus.done    = done_r;
  assign bus.result  = result_r;
  assign bus.res_reg = res_reg_r;

endmodule
